goe_bank_selector: RTL

//  Bank of CHANNELS macrocell output-enable selectors.

---
 rtl/goe_bank_selector.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/goe_bank_selector.sv
// goe_bank_selector: bank of macrocell output-enable selectors.
// Each channel picks its registered output enable from the global OE lines,
// its own product term, or constant 0, using a 3-bit code held in an active
// config register. Codes are loaded through a serial shadow chain and moved
// into the active register by a commit handshake that checks the bit count.
// Optional macro GOE_SYNC_EN: goe passes a 2-flop synchroniser before selection.
module goe_bank_selector #(
    parameter int CHANNELS = 16,
    parameter int NUM_GOE  = 6
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_GOE-1:0]  i_goe,
    input  logic [CHANNELS-1:0] i_vcc_pt,
    input  logic                i_cfg_shift,
    input  logic                i_cfg_sdi,
    input  logic                i_cfg_commit,
    output logic                o_cfg_sdo,
    output logic                o_cfg_ready,
    output logic                o_cfg_done,
    output logic                o_cfg_err,
    output logic [CHANNELS-1:0] o_qoe
);

    localparam int TOTAL = 3 * CHANNELS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL);

    // state    | meaning
    // ST_IDLE  | accepting shift and commit requests
    // ST_COMMIT| checking the bit count, transferring shadow to active
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TOTAL-1:0]    r_shadow;
    logic [TOTAL-1:0]    r_active;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;
    logic                r_sdo;
    logic                r_done;
    logic                r_err;
    logic [CHANNELS-1:0] r_qoe;
    logic [CHANNELS-1:0] w_qoe_nxt;
    logic                w_do_shift;
    logic                w_commit_ok;
    logic                w_commit_bad;
    logic [NUM_GOE-1:0]  w_goe_use;
    logic [5:0]          w_goe_sel;

`ifdef GOE_SYNC_EN
    logic [NUM_GOE-1:0]  r_goe_meta;
    logic [NUM_GOE-1:0]  r_goe_sync;

    // Two-flop synchroniser on the global OE lines.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_goe_meta <= '0;
            r_goe_sync <= '0;
        end else begin
            r_goe_meta <= i_goe;
            r_goe_sync <= r_goe_meta;
        end
    end

    assign w_goe_use = r_goe_sync;
`else
    assign w_goe_use = i_goe;
`endif

    // Absent global OE lines read as 0 so out-of-range codes give a disabled output.
    for (genvar g = 0; g < 6; g++) begin : g_goe_pad
        if (g < NUM_GOE) begin : g_present
            assign w_goe_sel[g] = w_goe_use[g];
        end else begin : g_absent
            assign w_goe_sel[g] = 1'b0;
        end
    end

    function automatic logic oe_select(input logic [2:0] code,
                                       input logic [5:0] goe_lines,
                                       input logic       pt);
        logic sel;
        case (code)
            3'b000:  sel = 1'b0;
            3'b001:  sel = goe_lines[0];
            3'b100:  sel = goe_lines[1];
            3'b101:  sel = goe_lines[2];
            3'b010:  sel = goe_lines[3];
            3'b011:  sel = goe_lines[4];
            3'b110:  sel = goe_lines[5];
            default: sel = pt;
        endcase
        return sel;
    endfunction

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and request decode; a shift wins over a simultaneous commit.
    always_comb begin
        w_state_nxt  = r_state;
        w_do_shift   = 1'b0;
        w_commit_ok  = 1'b0;
        w_commit_bad = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cfg_shift) begin
                    w_do_shift = 1'b1;
                end else if (i_cfg_commit) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
                if ((r_count == TOTAL_CNT) && !r_ovf) begin
                    w_commit_ok = 1'b1;
                end else begin
                    w_commit_bad = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shadow chain, bit counter with overflow flag, active transfer and status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_sdo    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_commit_ok;
            r_err  <= w_commit_bad;
            if (w_do_shift) begin
                r_shadow <= {r_shadow[TOTAL-2:0], i_cfg_sdi};
                r_sdo    <= r_shadow[TOTAL-1];
                if (r_count == TOTAL_CNT) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_commit_ok) begin
                r_active <= r_shadow;
            end
            if (w_commit_ok || w_commit_bad) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end

    // Per-channel selection from the active codes.
    always_comb begin
        w_qoe_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_qoe_nxt[c] = oe_select(r_active[3*c +: 3], w_goe_sel, i_vcc_pt[c]);
        end
    end

    // Registered output enables.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_qoe <= '0;
        end else begin
            r_qoe <= w_qoe_nxt;
        end
    end

    assign o_cfg_sdo   = r_sdo;
    assign o_cfg_ready = (r_state == ST_IDLE);
    assign o_cfg_done  = r_done;
    assign o_cfg_err   = r_err;
    assign o_qoe       = r_qoe;

endmodule
